// File: rtl/snes_pad_responder.sv
// Peripheral end of an SNES joypad port: latches pad buttons on strobe and shifts them out
// on joy_clk rising edges; optionally emulates a 4-pad multitap selected by joy_p6.
module snes_pad_responder #(
  parameter int MULTITAP = 0
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [11:0] pad_a,
  input  logic [11:0] pad_b,
  input  logic [11:0] pad_c,
  input  logic [11:0] pad_d,
  input  logic        joy_strb,
  input  logic        joy_clk,
  input  logic        joy_p6,
  output logic [1:0]  joy_di
);

  localparam logic [4:0] CNT_END = 5'd16;

  logic        strb_r, clk_r, clk_prev, p6_r;
  logic [15:0] shift_a, shift_b, shift_c, shift_d;
  logic [4:0]  cnt_p, cnt_q;

  logic [15:0] shift_a_n, shift_b_n, shift_c_n, shift_d_n;
  logic [4:0]  cnt_p_n, cnt_q_n;
  logic [1:0]  di_n;
  logic        sel_p, rise, p_live, q_live;

  always_comb begin
    sel_p     = (MULTITAP == 0) || p6_r;
    rise      = clk_r & ~clk_prev;
    shift_a_n = shift_a;
    shift_b_n = shift_b;
    shift_c_n = shift_c;
    shift_d_n = shift_d;
    cnt_p_n   = cnt_p;
    cnt_q_n   = cnt_q;
    if (strb_r) begin
      // The 4 ID bits above the buttons are loaded as 0 (line driven high).
      shift_a_n = {4'b0000, pad_a};
      shift_b_n = {4'b0000, pad_b};
      shift_c_n = {4'b0000, pad_c};
      shift_d_n = {4'b0000, pad_d};
      cnt_p_n   = 5'd0;
      cnt_q_n   = 5'd0;
    end else if (rise) begin
      if (sel_p) begin
        shift_a_n = {1'b0, shift_a[15:1]};
        shift_b_n = {1'b0, shift_b[15:1]};
        if (cnt_p != CNT_END) cnt_p_n = cnt_p + 5'd1;
      end else begin
        shift_c_n = {1'b0, shift_c[15:1]};
        shift_d_n = {1'b0, shift_d[15:1]};
        if (cnt_q != CNT_END) cnt_q_n = cnt_q + 5'd1;
      end
    end
  end

  // Output is computed from next state so it lands 2 mclk after the pin change.
  always_comb begin
    p_live = (cnt_p_n != CNT_END);
    q_live = (cnt_q_n != CNT_END);
    di_n   = 2'b11;
    if (MULTITAP == 0) begin
      di_n = {1'b1, p_live & ~shift_a_n[0]};
    end else if (strb_r) begin
      di_n = {1'b0, ~(sel_p ? shift_a_n[0] : shift_c_n[0])};
    end else if (sel_p) begin
      di_n = p_live ? ~{shift_b_n[0], shift_a_n[0]} : 2'b00;
    end else begin
      di_n = q_live ? ~{shift_d_n[0], shift_c_n[0]} : 2'b00;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      strb_r   <= 1'b0;
      clk_r    <= 1'b1;
      clk_prev <= 1'b1;
      p6_r     <= 1'b1;
      shift_a  <= '0;
      shift_b  <= '0;
      shift_c  <= '0;
      shift_d  <= '0;
      cnt_p    <= '0;
      cnt_q    <= '0;
      joy_di   <= 2'b11;
    end else begin
      strb_r   <= joy_strb;
      clk_r    <= joy_clk;
      clk_prev <= clk_r;
      p6_r     <= joy_p6;
      shift_a  <= shift_a_n;
      shift_b  <= shift_b_n;
      shift_c  <= shift_c_n;
      shift_d  <= shift_d_n;
      cnt_p    <= cnt_p_n;
      cnt_q    <= cnt_q_n;
      joy_di   <= di_n;
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Scoreboard bench for snes_pad_responder: one single-pad and one multitap instance share
// the console-side stimulus; a bit-position model predicts both data outputs.
module tb_snes_pad_responder;

  logic        mclk = 1'b0;
  logic        rst;
  logic [11:0] pad_a, pad_b, pad_c, pad_d;
  logic        joy_strb, joy_clk, joy_p6;
  logic [1:0]  di_s, di_m;

  always #5 mclk = ~mclk;

  snes_pad_responder #(.MULTITAP(0)) dut_s (
    .mclk(mclk), .rst(rst), .pad_a(pad_a), .pad_b(pad_b), .pad_c(pad_c), .pad_d(pad_d),
    .joy_strb(joy_strb), .joy_clk(joy_clk), .joy_p6(joy_p6), .joy_di(di_s)
  );

  snes_pad_responder #(.MULTITAP(1)) dut_m (
    .mclk(mclk), .rst(rst), .pad_a(pad_a), .pad_b(pad_b), .pad_c(pad_c), .pad_d(pad_d),
    .joy_strb(joy_strb), .joy_clk(joy_clk), .joy_p6(joy_p6), .joy_di(di_m)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    bit         multi;
    logic [1:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] fa, fb, fc, fd;
  int          s_pos, m_pp, m_pq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  function automatic logic [1:0] model_s();
    return {1'b1, (s_pos < 16) ? ~fa[s_pos] : 1'b0};
  endfunction

  function automatic logic [1:0] model_m();
    if (joy_strb) return {1'b0, ~(joy_p6 ? fa[0] : fc[0])};
    if (joy_p6)   return (m_pp < 16) ? ~{fb[m_pp], fa[m_pp]} : 2'b00;
    return (m_pq < 16) ? ~{fd[m_pq], fc[m_pq]} : 2'b00;
  endfunction

  task automatic latch_model();
    fa = {4'b0000, pad_a};
    fb = {4'b0000, pad_b};
    fc = {4'b0000, pad_c};
    fd = {4'b0000, pad_d};
    s_pos = 0; m_pp = 0; m_pq = 0;
  endtask

  task automatic clear_model();
    fa = '0; fb = '0; fc = '0; fd = '0;
    s_pos = 0; m_pp = 0; m_pq = 0;
  endtask

  task automatic push_both(input string tag);
    exp_q.push_back('{tag: {tag, "_s"}, multi: 1'b0, val: model_s()});
    exp_q.push_back('{tag: {tag, "_m"}, multi: 1'b1, val: model_m()});
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, e.multi ? {30'd0, di_m} : {30'd0, di_s}, {30'd0, e.val});
    end
  endtask

  task automatic strobe_pulse(input string tag);
    joy_strb = 1'b1;
    latch_model();
    tick(2);
    push_both({tag, "_hi"});
    drain();
    joy_strb = 1'b0;
    tick(2);
    push_both({tag, "_b0"});
    drain();
  endtask

  task automatic clk_pulse(input string tag);
    joy_clk = 1'b0;
    tick(2);
    joy_clk = 1'b1;
    if (joy_strb) latch_model();
    else begin
      if (s_pos < 16) s_pos++;
      if (joy_p6) begin if (m_pp < 16) m_pp++; end
      else begin if (m_pq < 16) m_pq++; end
    end
    tick(2);
    push_both(tag);
    drain();
  endtask

  task automatic set_p6(input logic v, input string tag);
    joy_p6 = v;
    tick(2);
    push_both(tag);
    drain();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    pad_a = '0; pad_b = '0; pad_c = '0; pad_d = '0;
    joy_strb = 1'b0; joy_clk = 1'b1; joy_p6 = 1'b1;
    clear_model();
    tick(2);
    check_val("rst_di_s", {30'd0, di_s}, 32'h3);
    check_val("rst_di_m", {30'd0, di_m}, 32'h3);
    check_val("rst_cnt_p", {27'd0, dut_s.cnt_p}, 32'd0);
    rst = 1'b0;
    tick(1);

    // B-only frame
    pad_a = 12'h001;
    strobe_pulse("t1_strb");
    for (int i = 1; i <= 16; i++) clk_pulse($sformatf("t1_bit%0d", i));

    // all pressed, run past saturation
    pad_a = 12'hFFF;
    strobe_pulse("t2_strb");
    for (int i = 1; i <= 20; i++) clk_pulse($sformatf("t2_bit%0d", i));
    check_val("t2_cnt_sat", {27'd0, dut_s.cnt_p}, 32'd16);

    // pad change mid-frame must not disturb the frame
    pad_a = 12'h0A5;
    strobe_pulse("t3_strb");
    for (int i = 1; i <= 3; i++) clk_pulse($sformatf("t3_bit%0d", i));
    pad_a = 12'h800;
    for (int i = 4; i <= 16; i++) clk_pulse($sformatf("t3_bit%0d", i));
    strobe_pulse("t3_relatch");
    for (int i = 1; i <= 11; i++) clk_pulse($sformatf("t3r_bit%0d", i));

    // strobe and clock rising together mid-frame
    pad_a = 12'h002;
    strobe_pulse("t4_strb");
    for (int i = 1; i <= 3; i++) clk_pulse($sformatf("t4_bit%0d", i));
    pad_a = 12'h001;
    joy_clk = 1'b0;
    tick(2);
    joy_strb = 1'b1;
    joy_clk  = 1'b1;
    latch_model();
    tick(2);
    push_both("t4_simul");
    drain();
    check_val("t4_cnt0", {27'd0, dut_s.cnt_p}, 32'd0);
    joy_strb = 1'b0;
    tick(2);
    push_both("t4_fall");
    drain();
    for (int i = 1; i <= 2; i++) clk_pulse($sformatf("t4_after%0d", i));

    // reset mid-frame
    pad_a = 12'h0FF;
    strobe_pulse("t5_strb");
    for (int i = 1; i <= 5; i++) clk_pulse($sformatf("t5_bit%0d", i));
    rst = 1'b1;
    tick(1);
    check_val("t5_rst_di_s", {30'd0, di_s}, 32'h3);
    check_val("t5_rst_di_m", {30'd0, di_m}, 32'h3);
    check_val("t5_rst_cnt_s", {27'd0, dut_s.cnt_p}, 32'd0);
    check_val("t5_rst_cnt_p", {27'd0, dut_m.cnt_p}, 32'd0);
    check_val("t5_rst_cnt_q", {27'd0, dut_m.cnt_q}, 32'd0);
    rst = 1'b0;
    clear_model();
    pad_a = 12'h003;
    strobe_pulse("t5_clean");
    for (int i = 1; i <= 2; i++) clk_pulse($sformatf("t5c_bit%0d", i));

    // multitap: detection signature, pair selection and hold
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_model();
    pad_a = 12'h000; pad_b = 12'h002; pad_c = 12'h000; pad_d = 12'h004;
    joy_p6 = 1'b1;
    joy_strb = 1'b1;
    latch_model();
    tick(1);
    check_val("mt_lat1", {31'd0, di_m[1]}, 32'd1);
    tick(1);
    check_val("mt_lat2", {31'd0, di_m[1]}, 32'd0);
    push_both("mt_strb");
    drain();
    joy_strb = 1'b0;
    tick(2);
    push_both("mt_b0");
    drain();
    clk_pulse("mt_p_bit1");
    set_p6(1'b0, "mt_sel_q");
    clk_pulse("mt_q_bit1");
    clk_pulse("mt_q_bit2");
    set_p6(1'b1, "mt_back_p");
    check_val("mt_cnt_p", {27'd0, dut_m.cnt_p}, 32'd1);
    check_val("mt_cnt_q", {27'd0, dut_m.cnt_q}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
